fwd_mux_stage: RTL and testbench

- Parametrised NSRC:1 operand-select mux with a registered, back-pressured output stage for the pipelined ARM datapath.
- Used for forwarding and operand selection between register-file read, EX/MEM result, MEM/WB result, and immediate.
- Holds a full-throughput valid/ready pipeline stage (output register plus one-entry skid buffer) so that a downstream stall never drops a selected operand.
- Adds flush, out-of-range select detection and a transfer counter.

---
 rtl/fwd_mux_stage.sv | 94 +++++++++
 tb/tb_fwd_mux_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_mux_stage.sv
// Operand-select mux for the forwarding network, followed by a registered
// valid/ready output stage with a one-entry skid buffer, flush and a transfer counter.
module fwd_mux_stage #(
    parameter int WIDTH = 64,
    parameter int NSRC  = 4,
    parameter int SELW  = $clog2(NSRC),
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out,
    output logic [SELW-1:0]       out_sel,
    output logic                  sel_err,
    output logic [CNTW-1:0]       xfer_cnt
);

    logic [NSRC-1:0][WIDTH-1:0] src;
    logic [WIDTH-1:0]           data;
    logic                       sel_bad;
    logic                       skid_valid;
    logic [WIDTH-1:0]           skid_data;
    logic [SELW-1:0]            skid_sel;
    logic                       acc;
    logic                       snd;

    assign src = in;

    // An index with no matching source yields zero and flags sel_bad; with a
    // power-of-two NSRC every index matches, so sel_bad can never assert.
    always_comb begin
        data    = '0;
        sel_bad = 1'b1;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SELW'(i)) begin
                data    = src[i];
                sel_bad = 1'b0;
            end
        end
    end

    assign in_ready = ~skid_valid;
    assign acc      = in_valid & in_ready & ~flush;
    assign snd      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out        <= '0;
            out_sel    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            sel_err    <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            if (snd)
                xfer_cnt <= xfer_cnt + CNTW'(1);
            if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else begin
                if (acc && sel_bad)
                    sel_err <= 1'b1;
                if (!out_valid || out_ready) begin
                    // Skid entry is older than anything arriving now, so it goes first.
                    if (skid_valid) begin
                        out        <= skid_data;
                        out_sel    <= skid_sel;
                        out_valid  <= 1'b1;
                        skid_valid <= 1'b0;
                    end else if (acc) begin
                        out       <= data;
                        out_sel   <= sel;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end else if (acc) begin
                    skid_data  <= data;
                    skid_sel   <= sel;
                    skid_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwd_mux_stage.sv
// Scoreboard bench for fwd_mux_stage: a 4-source instance with a 4-bit counter
// driven through a FIFO model, plus a 3-source instance for select-error cases.
module tb_fwd_mux_stage;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush, out_valid, out_ready, sel_err;
    logic [1:0]    sel, out_sel;
    logic [4*W-1:0] in_bus;
    logic [W-1:0]  out;
    logic [3:0]    xfer_cnt;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
    logic [1:0]    b_sel, b_out_sel;
    logic [3*W-1:0] b_in;
    logic [W-1:0]  b_out;
    logic [15:0]   b_xfer_cnt;

    exp_t          q[$];
    logic [3:0]    m_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    fwd_mux_stage #(.WIDTH(W), .NSRC(4), .CNTW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .in(in_bus), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_sel(out_sel),
        .sel_err(sel_err), .xfer_cnt(xfer_cnt)
    );

    fwd_mux_stage #(.WIDTH(W), .NSRC(3), .CNTW(16)) dut3 (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .in(b_in), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out(b_out), .out_sel(b_out_sel),
        .sel_err(b_sel_err), .xfer_cnt(b_xfer_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        in_bus[i*W +: W] = v;
    endtask

    // One clock: check the main instance against the model, then advance both.
    task automatic tick();
        logic m_acc, m_snd;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("xfer_cnt", xfer_cnt, m_cnt);
        chk("sel_err_pow2", sel_err, 0);
        if (q.size() > 0) begin
            chk("out", out, q[0].data);
            chk("out_sel", out_sel, q[0].sel);
        end
        m_snd = (q.size() > 0) && out_ready;
        m_acc = in_valid && (q.size() < 2) && !flush;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_cnt = '0;
        end else begin
            if (m_snd) m_cnt++;
            if (flush) q.delete();
            else begin
                if (m_snd) void'(q.pop_front());
                if (m_acc) q.push_back('{data: in_bus[sel*W +: W], sel: sel});
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        sel = '0; in_bus = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0; b_sel = '0; b_in = '0;
        m_cnt = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single operand from source 2
        set_src(2, 64'hDEAD_BEEF); sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t1_cnt", xfer_cnt, 1);

        // Back-to-back stream across all sources
        for (int i = 0; i < 4; i++) set_src(i, 64'(i + 10));
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();

        // Stall: fill output and skid, third input refused, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        set_src(1, 64'd5); sel = 2'd1; tick();
        set_src(3, 64'd7); sel = 2'd3; tick();
        set_src(0, 64'd99); sel = 2'd0; tick();
        chk("t3_in_ready", in_ready, 0);
        in_valid = 1'b0; tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush with output and skid full; flushed-cycle input is dropped
        out_ready = 1'b0; in_valid = 1'b1;
        set_src(0, 64'hA0); sel = 2'd0; tick();
        set_src(1, 64'hA1); sel = 2'd1; tick();
        set_src(2, 64'hA2); sel = 2'd2; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; tick();
        chk("t5_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (2) tick();

        // Random traffic with random back-pressure
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) set_src(j, {$urandom, $urandom});
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        // Out-of-range select on the 3-source instance
        b_in = '1; b_sel = 2'd3; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t4_valid", b_out_valid, 1);
        chk("t4_out_zero", b_out, 0);
        chk("t4_out_sel", b_out_sel, 3);
        chk("t4_sel_err", b_sel_err, 1);
        b_in[1*W +: W] = 64'h55; b_sel = 2'd1; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        chk("t4_out_valid_src", b_out, 64'h55);
        chk("t4_sel_err_sticky", b_sel_err, 1);
        tick();

        // Counter wrap after reset: 17 transfers on a 4-bit counter
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t4_sel_err_reset", b_sel_err, 0);
        b_sel = 2'd3; b_in_valid = 1'b1; b_flush = 1'b1;
        tick();
        b_in_valid = 1'b0; b_flush = 1'b0;
        chk("t4_flush_no_err", b_sel_err, 0);
        chk("t4_flush_no_valid", b_out_valid, 0);

        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            sel = 2'(i % 4);
            set_src(i % 4, 64'(100 + i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("t6_wrap", xfer_cnt, 1);

        // Reset while holding data
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3; set_src(3, 64'hBEEF);
        tick(); tick();
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0;
        tick();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_out", out, 0);
        chk("t6_rst_out_sel", out_sel, 0);
        chk("t6_rst_cnt", xfer_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
